id_ex_stage: RTL and testbench

ID/EX pipeline stage that registers decoded instruction fields and presents resolved operands and `alu_ctrl` to the execute-stage ALU. It also does the following:
- forwards results from the EX/MEM and MEM/WB stages onto the operands;
- detects load-use hazards and stalls the decode stage;
- inserts bubbles on stall or flush.

It sits between the decoder/register file and the ALU.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/forward_mux.sv | 40 ++++
 rtl/id_ex_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths and ALU operation codes.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned REGW = 5;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

endpackage : riscv_pkg

// File: rtl/forward_mux.sv
// Operand forwarding mux: picks the newest producer of register rs.
// Ports:
//   rs               - source register index held in EX
//   reg_data         - value read from the register file at decode
//   exmem_*          - EX/MEM producer (enable, index, value), highest priority
//   memwb_*          - MEM/WB producer (enable, index, value)
//   value            - resolved operand
module forward_mux #(
   parameter int unsigned XLEN = riscv_pkg::XLEN,
   parameter int unsigned REGW = riscv_pkg::REGW
) (
   input  logic [REGW-1:0] rs,
   input  logic [XLEN-1:0] reg_data,
   input  logic            exmem_reg_write,
   input  logic [REGW-1:0] exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_reg_write,
   input  logic [REGW-1:0] memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] value
);

   logic exmem_hit;
   logic memwb_hit;

   // x0 is hard-wired to zero, so a producer targeting it is never a match
   assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
   assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

   // EX/MEM is the younger result, so it wins over MEM/WB
   always_comb begin
      value = reg_data;
      if (exmem_hit) begin
         value = exmem_result;
      end else if (memwb_hit) begin
         value = memwb_result;
      end
   end

endmodule : forward_mux

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and bubble insertion.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   id_*                 - decoded instruction fields and register-file data
//   flush                - discard the instruction entering EX
//   exmem_*, memwb_*     - forwarding sources from later stages
//   id_stall             - combinational: hold PC and IF/ID this cycle
//   ex_valid/reg_write/mem_read/rd/alu_ctrl - registered control for EX
//   ex_a, ex_b, ex_store_data - forwarded operands (combinational on registered state)
module id_ex_stage #(
   parameter int unsigned XLEN = riscv_pkg::XLEN,
   parameter int unsigned REGW = riscv_pkg::REGW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [2:0]      id_alu_ctrl,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_alu_src,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            flush,
   input  logic            exmem_reg_write,
   input  logic [REGW-1:0] exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_reg_write,
   input  logic [REGW-1:0] memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic            id_stall,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic [REGW-1:0] ex_rd,
   output logic [2:0]      ex_alu_ctrl,
   output logic [XLEN-1:0] ex_a,
   output logic [XLEN-1:0] ex_b,
   output logic [XLEN-1:0] ex_store_data
);

   import riscv_pkg::*;

   logic            valid_q,     valid_d;
   logic [2:0]      alu_ctrl_q,  alu_ctrl_d;
   logic [REGW-1:0] rs1_q,       rs1_d;
   logic [REGW-1:0] rs2_q,       rs2_d;
   logic [REGW-1:0] rd_q,        rd_d;
   logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
   logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
   logic [XLEN-1:0] imm_q,       imm_d;
   logic            alu_src_q,   alu_src_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_read_q,  mem_read_d;

   logic            hazard;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   // Load in EX whose result the decoding instruction needs next cycle
   assign hazard = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                   ((rd_q == id_rs1) || (rd_q == id_rs2));

   // A flushed instruction is discarded anyway, so there is nothing to hold
   assign id_stall = hazard && !flush;

   // Next-state: bubble on flush/hazard, otherwise capture decode fields
   always_comb begin
      valid_d     = 1'b0;
      alu_ctrl_d  = ALU_ADD;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      if (!(flush || hazard)) begin
         valid_d     = id_valid;
         alu_ctrl_d  = id_alu_ctrl;
         rs1_d       = id_rs1;
         rs2_d       = id_rs2;
         rd_d        = id_rd;
         rs1_data_d  = id_rs1_data;
         rs2_data_d  = id_rs2_data;
         imm_d       = id_imm;
         alu_src_d   = id_alu_src;
         // An invalid slot must never write back or look like a load
         reg_write_d = id_reg_write && id_valid;
         mem_read_d  = id_mem_read && id_valid;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         alu_ctrl_q  <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         alu_ctrl_q  <= alu_ctrl_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         alu_src_q   <= alu_src_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
      end
   end

   forward_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
      .rs              (rs1_q),
      .reg_data        (rs1_data_q),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .value           (fwd_rs1)
   );

   forward_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
      .rs              (rs2_q),
      .reg_data        (rs2_data_q),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .value           (fwd_rs2)
   );

   assign ex_valid      = valid_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_rd         = rd_q;
   assign ex_alu_ctrl   = alu_ctrl_q;
   assign ex_a          = fwd_rs1;
   assign ex_b          = alu_src_q ? imm_q : fwd_rs2;
   assign ex_store_data = fwd_rs2;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

   localparam int unsigned XLEN = 32;
   localparam int unsigned REGW = 5;

   logic            clk;
   logic            rst_n;
   logic            id_valid;
   logic [2:0]      id_alu_ctrl;
   logic [REGW-1:0] id_rs1, id_rs2, id_rd;
   logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
   logic            id_alu_src, id_reg_write, id_mem_read;
   logic            flush;
   logic            exmem_reg_write;
   logic [REGW-1:0] exmem_rd;
   logic [XLEN-1:0] exmem_result;
   logic            memwb_reg_write;
   logic [REGW-1:0] memwb_rd;
   logic [XLEN-1:0] memwb_result;
   logic            id_stall, ex_valid, ex_reg_write, ex_mem_read;
   logic [REGW-1:0] ex_rd;
   logic [2:0]      ex_alu_ctrl;
   logic [XLEN-1:0] ex_a, ex_b, ex_store_data;

   int checks   = 0;
   int failures = 0;

   id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid        (id_valid),
      .id_alu_ctrl     (id_alu_ctrl),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rd           (id_rd),
      .id_rs1_data     (id_rs1_data),
      .id_rs2_data     (id_rs2_data),
      .id_imm          (id_imm),
      .id_alu_src      (id_alu_src),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .flush           (flush),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .id_stall        (id_stall),
      .ex_valid        (ex_valid),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_alu_ctrl     (ex_alu_ctrl),
      .ex_a            (ex_a),
      .ex_b            (ex_b),
      .ex_store_data   (ex_store_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [2:0] ctrl,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic src, input logic rw, input logic mr);
      id_valid     = v;
      id_alu_ctrl  = ctrl;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_rs1_data  = d1;
      id_rs2_data  = d2;
      id_imm       = imm;
      id_alu_src   = src;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
      exmem_reg_write = ew;
      exmem_rd        = erd;
      exmem_result    = eres;
      memwb_reg_write = mw;
      memwb_rd        = mrd;
      memwb_result    = mres;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"},     32'(id_stall),      32'h0);
      check({tag, "_valid"},     32'(ex_valid),      32'h0);
      check({tag, "_reg_write"}, 32'(ex_reg_write),  32'h0);
      check({tag, "_mem_read"},  32'(ex_mem_read),   32'h0);
      check({tag, "_rd"},        32'(ex_rd),         32'h0);
      check({tag, "_alu_ctrl"},  32'(ex_alu_ctrl),   32'h0);
      check({tag, "_a"},         ex_a,               32'h0);
      check({tag, "_b"},         ex_b,               32'h0);
      check({tag, "_store"},     ex_store_data,      32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      drive_id(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      #2;

      // add x6,x5,x1 with x1=3, rs1_data stale 0
      drive_id(1'b1, 3'b000, 5'd5, 5'd1, 5'd6, 32'h0, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      check("add_valid", 32'(ex_valid), 32'h1);
      check("add_rd", 32'(ex_rd), 32'd6);
      check("add_reg_write", 32'(ex_reg_write), 32'h1);
      check("nofwd_a", ex_a, 32'h0);
      set_fwd(1'b1, 5'd5, 32'h10, 1'b0, 5'd0, 32'h0);
      #1;
      check("exmem_a", ex_a, 32'h10);
      check("exmem_b", ex_b, 32'h3);

      // both sources match x5: EX/MEM wins; with exmem_rd=0 MEM/WB is used
      set_fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
      #1;
      check("double_a", ex_a, 32'hAA);
      set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd5, 32'hBB);
      #1;
      check("x0_ignored_a", ex_a, 32'hBB);
      set_fwd(1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
      #1;
      check("memwb_only_a", ex_a, 32'hBB);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // immediate select with forwarded rs2; rs1=x0 never forwarded
      drive_id(1'b1, 3'b011, 5'd0, 5'd4, 5'd10, 32'h7, 32'h99, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0);
      tick();
      set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd4, 32'h55);
      #1;
      check("imm_b", ex_b, 32'hFFFFFFFC);
      check("imm_store", ex_store_data, 32'h55);
      check("imm_a_x0", ex_a, 32'h7);
      check("imm_ctrl", 32'(ex_alu_ctrl), 32'h3);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // load-use: lw x8 in EX, sub x9,x8,x2 in ID
      drive_id(1'b1, 3'b000, 5'd1, 5'd0, 5'd8, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1);
      tick();
      check("load_mem_read", 32'(ex_mem_read), 32'h1);
      drive_id(1'b1, 3'b001, 5'd8, 5'd2, 5'd9, 32'h0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("lu_stall", 32'(id_stall), 32'h1);
      tick();
      check("lu_bubble_valid", 32'(ex_valid), 32'h0);
      check("lu_bubble_reg_write", 32'(ex_reg_write), 32'h0);
      check("lu_bubble_rd", 32'(ex_rd), 32'h0);
      check("lu_stall_clear", 32'(id_stall), 32'h0);
      tick();
      set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h1234);
      #1;
      check("lu_sub_valid", 32'(ex_valid), 32'h1);
      check("lu_sub_rd", 32'(ex_rd), 32'd9);
      check("lu_sub_ctrl", 32'(ex_alu_ctrl), 32'h1);
      check("lu_sub_a", ex_a, 32'h1234);
      check("lu_sub_b", ex_b, 32'h20);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // flush together with a load-use hazard (dependency through rs2)
      drive_id(1'b1, 3'b000, 5'd1, 5'd0, 5'd8, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 3'b001, 5'd2, 5'd8, 5'd9, 32'h0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("rs2_hazard_stall", 32'(id_stall), 32'h1);
      flush = 1'b1;
      #1;
      check("flush_stall", 32'(id_stall), 32'h0);
      tick();
      flush = 1'b0;
      check("flush_valid", 32'(ex_valid), 32'h0);
      check("flush_rd", 32'(ex_rd), 32'h0);
      check("flush_reg_write", 32'(ex_reg_write), 32'h0);

      // plain flush of a non-hazard instruction
      drive_id(1'b1, 3'b010, 5'd3, 5'd4, 5'd11, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_plain_valid", 32'(ex_valid), 32'h0);
      check("flush_plain_ctrl", 32'(ex_alu_ctrl), 32'h0);

      // invalid slot: control writes forced off, other fields captured
      drive_id(1'b0, 3'b010, 5'd3, 5'd4, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b1);
      tick();
      check("inv_valid", 32'(ex_valid), 32'h0);
      check("inv_reg_write", 32'(ex_reg_write), 32'h0);
      check("inv_mem_read", 32'(ex_mem_read), 32'h0);
      check("inv_rd", 32'(ex_rd), 32'd3);

      // load targeting x0 never stalls
      drive_id(1'b1, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 3'b000, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("x0_load_stall", 32'(id_stall), 32'h0);

      // reset mid-stream with a load of x7 in EX
      drive_id(1'b1, 3'b000, 5'd7, 5'd7, 5'd7, 32'h77, 32'h66, 32'h4, 1'b1, 1'b1, 1'b1);
      tick();
      check("pre_rst_valid", 32'(ex_valid), 32'h1);
      check("pre_rst_rd", 32'(ex_rd), 32'd7);
      set_fwd(1'b1, 5'd0, 32'h5A5A, 1'b1, 5'd0, 32'hA5A5);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      #1;
      rst_n = 1'b1;
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 3'b101, 5'd13, 5'd14, 5'd15, 32'hC0DE, 32'hBEEF, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      check("post_rst_valid", 32'(ex_valid), 32'h1);
      check("post_rst_rd", 32'(ex_rd), 32'd15);
      check("post_rst_ctrl", 32'(ex_alu_ctrl), 32'h5);
      check("post_rst_a", ex_a, 32'hC0DE);
      check("post_rst_b", ex_b, 32'hBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_id_ex_stage
